// File: rtl/core_pipe_ctrl_pkg.sv
// core_pipe_ctrl_pkg: controller states, pc_sel encodings and strobe bundles.
package core_pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, IMISS_KILL = 2'd2, DMISS = 2'd3} state_t;
  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_REDIR = 1'b1;
  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic if_id_we;
    logic if_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
  } strobes_t;
  localparam strobes_t S_RUN = 8'b1010_1011;
  localparam strobes_t S_FREEZE = 8'b0000_0000;
  localparam strobes_t S_RESET = 8'b0001_0100;
endpackage

// File: rtl/core_pipe_ctrl_if.sv
// core_pipe_ctrl_if: hazard/miss events in, stage strobes and perf counters out.
interface core_pipe_ctrl_if #(parameter int CNT_W = 16);
  logic ex_mispredict;
  logic id_ex_memread;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic ic_miss;
  logic ic_ready;
  logic dc_miss;
  logic dc_ready;
  logic pc_we;
  logic pc_sel;
  logic if_id_we;
  logic if_flush;
  logic id_ex_we;
  logic id_ex_flush;
  logic ex_mem_we;
  logic mem_wb_we;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    input ex_mispredict, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
    input ic_miss, ic_ready, dc_miss, dc_ready,
    output pc_we, pc_sel, if_id_we, if_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we,
    output stall_cnt, flush_cnt
  );
  modport slave (
    output ex_mispredict, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
    output ic_miss, ic_ready, dc_miss, dc_ready,
    input pc_we, pc_sel, if_id_we, if_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we,
    input stall_cnt, flush_cnt
  );
endinterface

// File: rtl/core_pipe_ctrl_lud.sv
// core_load_use_det: flags a load in ID/EX whose destination feeds the instruction in IF/ID.
module core_load_use_det (
  input  logic       i_id_ex_memread,
  input  logic [4:0] i_id_ex_rt,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  output logic       o_hazard
);
  assign o_hazard = i_id_ex_memread && (i_id_ex_rt != 5'd0) &&
                    (i_id_ex_rt == i_if_id_rs || i_id_ex_rt == i_if_id_rt);
endmodule

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: prioritised stall/flush sequencing for the 5-stage pipeline plus perf counters.
module core_pipe_ctrl
  import core_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  core_pipe_ctrl_if.master bus
);
  state_t r_state, r_ret, w_s, w_nxt, w_ret_nxt;
  logic r_ic_pend, w_pend_nxt;
  logic w_hz, w_dm, w_resume, w_icr, w_mp, w_flush_inc;
  strobes_t w_o;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  core_load_use_det u_lud (
    .i_id_ex_memread(bus.id_ex_memread),
    .i_id_ex_rt     (bus.id_ex_rt),
    .i_if_id_rs     (bus.if_id_rs),
    .i_if_id_rt     (bus.if_id_rt),
    .o_hazard       (w_hz)
  );
  assign w_dm = r_state == DMISS;
  assign w_resume = w_dm && bus.dc_ready;
  // On the dc_ready cycle the saved state decides the outputs, with a buffered refill replayed.
  assign w_s = w_resume ? r_ret : r_state;
  assign w_icr = bus.ic_ready || (w_resume && r_ic_pend);
  assign w_mp = bus.ex_mispredict && !w_dm;
  always_comb begin
    w_o = S_RUN;
    w_nxt = w_s;
    w_ret_nxt = r_ret;
    w_pend_nxt = r_ic_pend && !w_resume;
    w_flush_inc = 1'b0;
    if (w_dm && !bus.dc_ready) begin
      w_o = S_FREEZE;
      w_pend_nxt = r_ic_pend || bus.ic_ready;
    end else if (!w_dm && bus.dc_miss) begin
      w_o = S_FREEZE;
      w_nxt = DMISS;
      w_ret_nxt = r_state;
      w_pend_nxt = bus.ic_ready;
    end else if (w_mp) begin
      w_o.pc_sel = PC_REDIR;
      w_o.if_flush = 1'b1;
      w_o.id_ex_flush = 1'b1;
      w_flush_inc = 1'b1;
      w_nxt = (w_s == RUN) ? RUN : IMISS_KILL;
    end else begin
      case (w_s)
        IMISS: begin
          w_o.id_ex_flush = w_hz;
          w_o.pc_we = w_icr;
          w_o.if_flush = !w_icr;
          w_nxt = w_icr ? RUN : IMISS;
        end
        IMISS_KILL: begin
          w_o.pc_we = 1'b0;
          w_o.if_id_we = 1'b0;
          w_o.if_flush = 1'b1;
          w_o.id_ex_flush = w_hz;
          w_nxt = w_icr ? RUN : IMISS_KILL;
        end
        default: begin
          if (w_hz) begin
            w_o.pc_we = 1'b0;
            w_o.if_id_we = 1'b0;
            w_o.id_ex_flush = 1'b1;
          end else if (bus.ic_miss) begin
            w_o.pc_we = 1'b0;
            w_o.if_flush = 1'b1;
            w_nxt = IMISS;
          end
        end
      endcase
    end
    if (rst) w_o = S_RESET;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_ret <= RUN;
      r_ic_pend <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_ret <= w_ret_nxt;
      r_ic_pend <= w_pend_nxt;
      r_stall_cnt <= r_stall_cnt + CNT_W'(!w_o.pc_we && !(&r_stall_cnt));
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush_inc && !(&r_flush_cnt));
    end
  end
  assign bus.pc_we = w_o.pc_we;
  assign bus.pc_sel = w_o.pc_sel;
  assign bus.if_id_we = w_o.if_id_we;
  assign bus.if_flush = w_o.if_flush;
  assign bus.id_ex_we = w_o.id_ex_we;
  assign bus.id_ex_flush = w_o.id_ex_flush;
  assign bus.ex_mem_we = w_o.ex_mem_we;
  assign bus.mem_wb_we = w_o.mem_wb_we;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
endmodule
